// File: rtl/multicycle_ctrl_if.sv
// Shared instruction/data memory port between the multicycle control FSM and the memory.
// The controller is the master: it raises requests and the memory answers with mem_ready.
interface multicycle_ctrl_if;
    logic mem_req;
    logic mem_we;
    logic addr_sel;
    logic mem_ready;

    modport master (output mem_req, output mem_we, output addr_sel, input mem_ready);
    modport slave  (input mem_req, input mem_we, input addr_sel, output mem_ready);
endinterface

// File: rtl/multicycle_ctrl.sv
// Multicycle LEGv8 control FSM: sequences fetch/decode/execute/memory/writeback over one
// shared memory port, with a saturating wait counter that faults a stalled access.
module multicycle_ctrl #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_W          = 8
) (
    input  logic                clk,
    input  logic                reset,
    multicycle_ctrl_if.master   mem,
    input  logic [31:0]         instruction,
    input  logic                zero,
    output logic                ir_write,
    output logic                pc_write,
    output logic [1:0]          pc_src,
    output logic                reg_write,
    output logic                mem_to_reg,
    output logic                reg2_loc,
    output logic                alu_src,
    output logic [1:0]          alu_op,
    output logic [1:0]          imm_sel,
    output logic                instr_done,
    output logic                fault,
    output logic [3:0]          state
);

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        EXEC_R   = 4'd2,
        MEM_ADDR = 4'd3,
        MEM_RD   = 4'd4,
        MEM_WR   = 4'd5,
        WB_ALU   = 4'd6,
        WB_MEM   = 4'd7,
        BRANCH   = 4'd8,
        FAULT    = 4'd9
    } state_t;

    localparam logic [10:0] OP_ADD  = 11'd1112;
    localparam logic [10:0] OP_SUB  = 11'd1624;
    localparam logic [10:0] OP_AND  = 11'd1104;
    localparam logic [10:0] OP_ORR  = 11'd1360;
    localparam logic [10:0] OP_LDUR = 11'd1986;
    localparam logic [10:0] OP_STUR = 11'd1984;
    localparam logic [7:0]  OP_CBZ  = 8'd180;
    localparam logic [5:0]  OP_B    = 6'd5;

    // Timeout fires on the cycle whose increment would reach TIMEOUT_CYCLES.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [10:0] opc11;
    logic        is_r, is_ldur, is_stur, is_cbz, is_b;
    logic        unused_instr_bits;

    assign opc11   = instruction[31:21];
    assign is_cbz  = (instruction[31:24] == OP_CBZ);
    assign is_b    = (instruction[31:26] == OP_B);
    assign is_r    = (opc11 == OP_ADD) || (opc11 == OP_SUB) ||
                     (opc11 == OP_AND) || (opc11 == OP_ORR);
    assign is_ldur = (opc11 == OP_LDUR);
    assign is_stur = (opc11 == OP_STUR);
    assign unused_instr_bits = ^instruction[20:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= FETCH;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            FETCH, MEM_RD, MEM_WR: begin
                // mem_ready outranks the timeout compare in the same cycle.
                if (mem.mem_ready) begin
                    cnt_d = '0;
                    case (state_q)
                        FETCH:   state_d = DECODE;
                        MEM_RD:  state_d = WB_MEM;
                        default: state_d = FETCH;
                    endcase
                end else if (cnt_q >= CNT_LAST) begin
                    state_d = FAULT;
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DECODE: begin
                cnt_d = '0;
                if (is_cbz)                  state_d = BRANCH;
                else if (is_r)               state_d = EXEC_R;
                else if (is_ldur || is_stur) state_d = MEM_ADDR;
                else if (is_b)               state_d = BRANCH;
                else                         state_d = FAULT;
            end
            EXEC_R:   state_d = WB_ALU;
            MEM_ADDR: state_d = is_stur ? MEM_WR : MEM_RD;
            WB_ALU, WB_MEM, BRANCH: state_d = FETCH;
            FAULT:    state_d = FAULT;
            default:  state_d = FAULT;
        endcase
    end

    always_comb begin
        mem.mem_req  = 1'b0;
        mem.mem_we   = 1'b0;
        mem.addr_sel = 1'b0;
        ir_write     = 1'b0;
        pc_write     = 1'b0;
        pc_src       = 2'b10;
        reg_write    = 1'b0;
        mem_to_reg   = 1'b0;
        reg2_loc     = 1'b0;
        alu_src      = 1'b0;
        alu_op       = 2'b00;
        imm_sel      = 2'b00;
        instr_done   = 1'b0;
        fault        = 1'b0;
        // While reset is held every output sits at its idle value.
        if (!reset) begin
            case (state_q)
                FETCH: begin
                    mem.mem_req = 1'b1;
                    if (mem.mem_ready) begin
                        ir_write = 1'b1;
                        pc_write = 1'b1;
                        pc_src   = 2'b00;
                    end
                end
                DECODE: reg2_loc = is_cbz;
                EXEC_R: alu_op = 2'b10;
                MEM_ADDR: alu_src = 1'b1;
                MEM_RD: begin
                    mem.mem_req  = 1'b1;
                    mem.addr_sel = 1'b1;
                end
                MEM_WR: begin
                    mem.mem_req  = 1'b1;
                    mem.mem_we   = 1'b1;
                    mem.addr_sel = 1'b1;
                    reg2_loc     = 1'b1;
                    instr_done   = mem.mem_ready;
                end
                WB_ALU: begin
                    reg_write  = 1'b1;
                    instr_done = 1'b1;
                end
                WB_MEM: begin
                    reg_write  = 1'b1;
                    mem_to_reg = 1'b1;
                    instr_done = 1'b1;
                end
                BRANCH: begin
                    instr_done = 1'b1;
                    if (is_cbz) begin
                        imm_sel  = 2'b01;
                        alu_op   = 2'b01;
                        reg2_loc = 1'b1;
                        if (zero) begin
                            pc_write = 1'b1;
                            pc_src   = 2'b01;
                        end
                    end else begin
                        imm_sel  = 2'b10;
                        pc_write = 1'b1;
                        pc_src   = 2'b01;
                    end
                end
                FAULT: fault = 1'b1;
                default: fault = 1'b1;
            endcase
        end
    end

    assign state = state_q;

endmodule
